fifo_wr_sched: RTL and testbench

- Round-robin burst scheduler that shares one FIFO write port among NR producers.
- Sits in front of the team's standard `fifo` block: drives ffwreq/ffwdata and consumes ffwfull/ffvcnt.
- Grants one producer at a time a burst of up to BL beats, and starts a burst only when the FIFO has room for the whole burst.
- Guarantees the FIFO is never written while full; the FIFO itself has no overflow protection.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_sched.sv | 125 ++++++++++++
 tb/tb_fifo_wr_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and width helpers for the FIFO write scheduler
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Occupancy counter width: must hold 0..FD inclusive.
  function automatic int cnt_w(input int fd);
    return $clog2(fd) + 1;
  endfunction

  // Beat counter width: must hold 0..BL inclusive.
  function automatic int beat_w(input int bl);
    return $clog2(bl) + 1;
  endfunction

  function automatic int idx_w(input int nr);
    return (nr > 1) ? $clog2(nr) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NR = 4,
  parameter int IW = idx_w(NR)
) (
  input  logic [NR-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NR-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] w_j;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    w_j = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      w_j = IW'((int'(ptr) + k) % NR);
      if (req[w_j]) begin
        gnt      = '0;
        gnt[w_j] = 1'b1;
        idx      = w_j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// rtl/fifo_wr_sched.sv - round-robin burst scheduler sharing one FIFO write port
module fifo_wr_sched
  import fifo_pkg::*;
#(
  parameter int NR = 4,
  parameter int FD = 8,
  parameter int DW = 8,
  parameter int BL = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NR-1:0]          req_valid,
  input  logic [NR-1:0][DW-1:0]  req_data,
  input  logic [NR-1:0]          req_last,
  output logic [NR-1:0]          req_ready,
  input  logic                   ffwfull,
  input  logic [cnt_w(FD)-1:0]   ffvcnt,
  output logic                   ffwreq,
  output logic [DW-1:0]          ffwdata,
  output logic [idx_w(NR)-1:0]   gnt_id,
  output logic                   busy
);

  localparam int CW = cnt_w(FD);
  localparam int BW = beat_w(BL);
  localparam int IW = idx_w(NR);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IW-1:0]  r_gnt_id;
  logic [NR-1:0]  r_gnt_oh;
  logic [IW-1:0]  r_ptr;
  logic [BW-1:0]  r_beat;

  logic [NR-1:0]  w_pick_gnt;
  logic [IW-1:0]  w_pick_idx;
  logic           w_pick_any;
  logic [CW-1:0]  w_free;
  logic           w_room;
  logic           w_grant;
  logic           w_accept;
  logic           w_end;

  // A burst only starts when the whole burst fits, so the FIFO cannot fill mid-burst.
  assign w_free = CW'(FD) - ffvcnt;
  assign w_room = (ffvcnt <= CW'(FD)) && (w_free >= CW'(BL));

  rr_pick #(
    .NR (NR),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    ffwreq      = 1'b0;
    ffwdata     = '0;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any && w_room) begin
          w_grant     = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        req_ready = ffwfull ? '0 : r_gnt_oh;
        ffwreq    = (|(req_valid & r_gnt_oh)) & ~ffwfull;
        if (ffwreq) begin
          for (int i = 0; i < NR; i++) begin
            if (r_gnt_oh[i]) begin
              ffwdata = ffwdata | req_data[i];
            end
          end
        end
        w_accept = ffwreq;
        w_end    = w_accept && ((|(req_last & r_gnt_oh)) || (r_beat == BW'(BL - 1)));
        if (w_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt_id <= '0;
      r_gnt_oh <= '0;
      r_ptr    <= '0;
      r_beat   <= '0;
    end else begin
      if (w_grant) begin
        r_gnt_id <= w_pick_idx;
        r_gnt_oh <= w_pick_gnt;
        r_beat   <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_end) begin
        r_ptr <= (r_gnt_id == IW'(NR - 1)) ? '0 : r_gnt_id + 1'b1;
      end
    end
  end

  assign gnt_id = r_gnt_id;
  assign busy   = (r_state == BURST);

endmodule

// File: tb/tb_fifo_wr_sched.sv
// tb/tb_fifo_wr_sched.sv - randomized scoreboard bench for fifo_wr_sched
module tb_fifo_wr_sched;

  localparam int NR  = 4;
  localparam int FD  = 8;
  localparam int DW  = 8;
  localparam int BL  = 4;
  localparam int CW  = $clog2(FD) + 1;
  localparam int IW  = $clog2(NR);
  localparam int BIG = 1 << 30;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0][DW-1:0] req_data;
  logic [NR-1:0]         req_last;
  logic [NR-1:0]         req_ready;
  logic                  ffwfull;
  logic [CW-1:0]         ffvcnt;
  logic                  ffwreq;
  logic [DW-1:0]         ffwdata;
  logic [IW-1:0]         gnt_id;
  logic                  busy;

  fifo_wr_sched #(.NR(NR), .FD(FD), .DW(DW), .BL(BL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .ffwfull   (ffwfull),
    .ffvcnt    (ffvcnt),
    .ffwreq    (ffwreq),
    .ffwdata   (ffwdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            busy;
    int            gnt;
    logic [NR-1:0] ready;
    bit            wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   env_cnt = 0;
  int   m_owner = -1;
  int   m_beats = 0;
  int   m_ptr = 0;
  int   nd[NR];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: one expected record per scheduled cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("busy", int'(busy), int'(e.busy));
      chk("ffwreq", int'(ffwreq), int'(e.wr));
      chk("req_ready", int'(req_ready), int'(e.ready));
      chk("ffwdata", int'(ffwdata), int'(e.data));
      if (e.busy) chk("gnt_id", int'(gnt_id), e.gnt);
    end
  end

  // Drive one cycle, predict it with the reference model, then advance the FIFO environment.
  task automatic step(input int vmask, input int vpct, input int lpct, input int lbeat,
                      input int rpct, input int lim);
    logic [NR-1:0]         v;
    logic [NR-1:0]         l;
    logic [NR-1:0][DW-1:0] d;
    exp_t                  e;
    bit                    rd;
    bit                    wr;
    int                    j;
    for (int i = 0; i < NR; i++) begin
      v[i] = vmask[i] && ($urandom_range(99) < vpct) && (nd[i] <= lim);
      d[i] = v[i] ? DW'(nd[i]) : DW'($urandom);
      l[i] = ($urandom_range(99) < lpct) || (lbeat > 0 && m_owner == i && m_beats == lbeat - 1)
             || (nd[i] == lim);
    end
    req_valid = v;
    req_data  = d;
    req_last  = l;
    ffvcnt    = CW'(env_cnt);
    ffwfull   = (env_cnt >= FD);

    e.busy  = (m_owner >= 0);
    e.gnt   = 0;
    e.ready = '0;
    e.wr    = 1'b0;
    e.data  = '0;
    if (m_owner < 0) begin
      if (FD - env_cnt >= BL) begin
        for (int k = 0; k < NR; k++) begin
          j = (m_ptr + k) % NR;
          if (m_owner < 0 && v[j]) begin
            m_owner = j;
            m_beats = 0;
          end
        end
      end
    end else begin
      e.gnt = m_owner;
      if (env_cnt < FD) begin
        e.ready[m_owner] = 1'b1;
        if (v[m_owner]) begin
          e.wr = 1'b1;
          e.data = d[m_owner];
          m_beats++;
          nd[m_owner]++;
          if (l[m_owner] || m_beats == BL) begin
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
          end
        end
      end
    end
    sb.push_back(e);

    rd = (env_cnt > 0) && ($urandom_range(99) < rpct);
    #3;
    wr = ffwreq;
    @(posedge clk);
    #1;
    cyc++;
    env_cnt = env_cnt + int'(wr) - int'(rd);
    chk("fifo_bound", int'(env_cnt <= FD), 1);
  endtask

  // Let the current owner finish so the next phase starts from IDLE.
  task automatic settle();
    for (int n = 0; n < 40 && m_owner >= 0; n++) begin
      step(1 << m_owner, 100, 100, 0, 100, BIG);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '1;
    req_data  = '1;
    req_last  = '0;
    ffvcnt    = '0;
    ffwfull   = 1'b0;
    for (int i = 0; i < NR; i++) nd[i] = (i == 0) ? 'h11 : i * 'h40;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_ffwreq", int'(ffwreq), 0);
    chk("rst_ffwdata", int'(ffwdata), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    req_valid = '0;
    req_data  = '0;
    reset_n   = 1'b1;

    // Single producer, 0x11..0x14, last on the 4th beat.
    repeat (8) step('h1, 100, 0, 0, 0, 'h14);
    chk("p0_fill", env_cnt, 4);

    // Everyone busy, 2-beat bursts, FIFO drained every cycle.
    settle();
    env_cnt = 0;
    repeat (40) step('hF, 100, 0, 2, 100, BIG);

    // Not enough room, then one read makes exactly BL free.
    settle();
    env_cnt = 5;
    repeat (4) step('h2, 100, 0, 0, 0, BIG);
    chk("noroom_busy", int'(busy), 0);
    env_cnt = 4;
    step('h2, 100, 0, 0, 0, BIG);
    chk("room_busy", int'(busy), 1);
    chk("room_gnt", int'(gnt_id), 1);
    repeat (6) step('h2, 100, 0, 0, 100, BIG);

    // Owner with gaps in valid, bursts end on count.
    settle();
    env_cnt = 0;
    repeat (40) step('h4, 50, 0, 0, 100, BIG);

    // No reads: FIFO must fill to exactly FD and never beyond.
    settle();
    env_cnt = 0;
    repeat (40) step('hF, 80, 0, 0, 0, BIG);
    chk("full_cnt", env_cnt, FD);

    // Reset during beat 2 of a p2 burst.
    env_cnt = 0;
    for (int n = 0; n < 20 && !(m_owner == 2 && m_beats == 1); n++) step('h4, 100, 0, 0, 100, BIG);
    req_valid = 'h4;
    req_data  = '0;
    req_data[2] = DW'(nd[2]);
    req_last  = '0;
    ffvcnt    = CW'(env_cnt);
    ffwfull   = 1'b0;
    #2;
    chk("pre_rst_ffwreq", int'(ffwreq), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ffwreq", int'(ffwreq), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    req_valid = '0;
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    repeat (20) step('hF, 100, 0, 0, 100, BIG);

    // Long mixed random run.
    repeat (600) step('hF, 60, 25, 0, 50, BIG);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
